// File: rtl/bram_reinit_ctrl.sv
// Purpose: sweeps a simple-dual-port BRAM (FILL pattern, VERIFY read-back) and arbitrates one user port while idle.
// Latency: sweep = 2*DEPTH+1 cycles from accepted start to done; user read data returns 1 cycle after grant.
// Backpressure: usr_gnt is held low while busy (or when start wins); the requester holds usr_req and fields until granted.
//
// Ports:
//   clk, reset          single clock (posedge), asynchronous active-high reset
//   start, seed         1-cycle sweep request and pattern seed (sampled on accepted start)
//   busy, done          sweep in progress / 1-cycle pulse on the final (DRAIN) cycle
//   err_count, first_err, err_seen   mismatch results of the last sweep
//   usr_req/we/addr/wdata, usr_gnt, usr_rdata, usr_rvalid   user access port
//   mem_raddr, mem_waddr, mem_we, mem_din, mem_dout          RAM side (registered read, 1-cycle latency)
module bram_reinit_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4096,
  parameter int MULT   = 'h2F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err,
  output logic              err_seen,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] seed_q;
  logic              last;
  logic              start_acc;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic              rd_pend;

  // pattern(a) = a*MULT + seed, truncated to the word width
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] s);
    return DATA_W'(a) * DATA_W'(MULT) + s;
  endfunction

  assign last     = (cnt == LAST);
  assign busy     = (state != S_IDLE);
  assign mismatch = cmp_vld && (mem_dout != pattern(cmp_addr, seed_q));

  // Read data is only presented alongside its valid so idle cycles show zero.
  assign usr_rvalid = rd_pend;
  assign usr_rdata  = rd_pend ? mem_dout : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    usr_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_din   = '0;
    mem_raddr = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          // start takes priority over a simultaneous user request
          start_acc = 1'b1;
          state_nx  = S_FILL;
        end else if (usr_req) begin
          usr_gnt = 1'b1;
          if (usr_we) begin
            mem_we    = 1'b1;
            mem_waddr = usr_addr;
            mem_din   = usr_wdata;
          end else begin
            mem_raddr = usr_addr;
          end
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_din   = pattern(cnt, seed_q);
        if (last) state_nx = S_VERIFY;
      end
      S_VERIFY: begin
        mem_raddr = cnt;
        if (last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sweep address counter; returns to 0 at the end of each pass so VERIFY starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == S_FILL) || (state == S_VERIFY)) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q   <= '0;
      done     <= 1'b0;
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      rd_pend  <= 1'b0;
    end else begin
      if (start_acc) seed_q <= seed;
      // done is registered off the last VERIFY read so it lands in the DRAIN cycle
      done     <= (state == S_VERIFY) && last;
      // address of the read in flight, aligned with mem_dout one cycle later
      cmp_vld  <= (state == S_VERIFY);
      cmp_addr <= cnt;
      rd_pend  <= usr_gnt && !usr_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (start_acc) begin
      err_count <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (!err_seen) begin
        err_seen  <= 1'b1;
        first_err <= cmp_addr;
      end
    end
  end

endmodule
